// File: rtl/registro_if_id.sv
// IF/ID boundary register with a two-entry skid buffer and RISC-V field decode.
// Optional illegal-encoding flag is enabled by defining IFID_ILLEGAL_CHECK_EN.
//
// state | meaning
// ------+---------------------------------------
// VACIO | main register empty, nothing toward decode
// LLENO | main register holds the entry shown to decode
// SKID  | main and skid both full, input stalled
module registro_if_id (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Entrada_valid,
    output logic        Entrada_ready,
    input  logic [31:0] Instruccion,
    input  logic [31:0] PC_in,
    input  logic        Flush,
    output logic        Salida_valid,
    input  logic        Salida_ready,
    output logic [31:0] PC_out,
    output logic [6:0]  Opcode,
    output logic [4:0]  Rd,
    output logic [2:0]  Funct3,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    output logic [6:0]  Funct7,
    output logic [19:0] Inmediato_U,
    output logic        Es_U,
    output logic        Ilegal
);

    typedef enum logic [1:0] {
        VACIO = 2'b00,
        LLENO = 2'b01,
        SKID  = 2'b10
    } estado_t;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    estado_t     estado;
    estado_t     estado_sig;

    logic        in_fire;
    logic        out_fire;
    logic        cargar_main_in;
    logic        cargar_main_skid;
    logic        cargar_skid;

    logic [31:0] main_instr;
    logic [31:0] main_pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    assign in_fire  = Entrada_valid & Entrada_ready;
    assign out_fire = Salida_valid & Salida_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= VACIO;
        end else begin
            estado <= estado_sig;
        end
    end

    // Flush wins over every transition; any accepted input that cycle is dropped.
    always_comb begin
        estado_sig       = estado;
        cargar_main_in   = 1'b0;
        cargar_main_skid = 1'b0;
        cargar_skid      = 1'b0;
        if (Flush) begin
            estado_sig = VACIO;
        end else begin
            case (estado)
                VACIO: begin
                    if (in_fire) begin
                        estado_sig     = LLENO;
                        cargar_main_in = 1'b1;
                    end
                end
                LLENO: begin
                    if (in_fire && out_fire) begin
                        estado_sig     = LLENO;
                        cargar_main_in = 1'b1;
                    end else if (in_fire) begin
                        estado_sig  = SKID;
                        cargar_skid = 1'b1;
                    end else if (out_fire) begin
                        estado_sig = VACIO;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        estado_sig       = LLENO;
                        cargar_main_skid = 1'b1;
                    end
                end
                default: begin
                    estado_sig = VACIO;
                end
            endcase
        end
    end

    // Handshake outputs depend only on the state register.
    always_comb begin
        Salida_valid  = (estado != VACIO);
        Entrada_ready = (estado != SKID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_instr <= 32'h0;
            main_pc    <= 32'h0;
            skid_instr <= 32'h0;
            skid_pc    <= 32'h0;
        end else begin
            if (cargar_main_in) begin
                main_instr <= Instruccion;
                main_pc    <= PC_in;
            end else if (cargar_main_skid) begin
                main_instr <= skid_instr;
                main_pc    <= skid_pc;
            end
            if (cargar_skid) begin
                skid_instr <= Instruccion;
                skid_pc    <= PC_in;
            end
        end
    end

    assign PC_out      = main_pc;
    assign Opcode      = main_instr[6:0];
    assign Rd          = main_instr[11:7];
    assign Funct3      = main_instr[14:12];
    assign Rs1         = main_instr[19:15];
    assign Rs2         = main_instr[24:20];
    assign Funct7      = main_instr[31:25];
    assign Inmediato_U = main_instr[31:12];
    assign Es_U        = Salida_valid & ((Opcode == OP_LUI) | (Opcode == OP_AUIPC));

`ifdef IFID_ILLEGAL_CHECK_EN
    logic main_ilegal;
    logic skid_ilegal;
    logic entrada_ilegal;

    // Flag is computed on entry so it travels with the word through the skid.
    assign entrada_ilegal = (Instruccion[1:0] != 2'b11) |
                            (Instruccion == 32'h0000_0000) |
                            (Instruccion == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ilegal <= 1'b0;
            skid_ilegal <= 1'b0;
        end else begin
            if (cargar_main_in) begin
                main_ilegal <= entrada_ilegal;
            end else if (cargar_main_skid) begin
                main_ilegal <= skid_ilegal;
            end
            if (cargar_skid) begin
                skid_ilegal <= entrada_ilegal;
            end
        end
    end

    assign Ilegal = Salida_valid & main_ilegal;
`else
    assign Ilegal = 1'b0;
`endif

endmodule

// File: doc/registro_if_id.md
# registro_if_id

Registered IF/ID boundary stage between instruction fetch and decode. It accepts a fetched instruction and its PC over a valid/ready handshake and holds them in a two-entry skid-buffered register. From the held word it presents the decoded RISC-V fields, including the raw 20-bit U-type immediate consumed directly by the U-type sign-extend/shift unit. It also supports a synchronous flush for taken branches and jumps.

## Interface
No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- Entrada_valid  in  1  fetch presents Instruccion/PC_in
- Entrada_ready  out  1  stage can accept; driven only from state register
- Instruccion  in  32  fetched instruction word
- PC_in  in  32  PC of Instruccion
- Flush  in  1  discard all held and incoming entries
- Salida_valid  out  1  held entry valid toward decode
- Salida_ready  in  1  decode consumes held entry
- PC_out  out  32  PC of held entry
- Opcode  out  7  held[6:0]
- Rd  out  5  held[11:7]
- Funct3  out  3  held[14:12]
- Rs1  out  5  held[19:15]
- Rs2  out  5  held[24:20]
- Funct7  out  7  held[31:25]
- Inmediato_U  out  20  held[31:12], feeds U-type sign-extend
- Es_U  out  1  Salida_valid and Opcode is 0110111 (LUI) or 0010111 (AUIPC)
- Ilegal  out  1  illegal-encoding flag (see Configuration)

## Operation
- in_fire = Entrada_valid & Entrada_ready. out_fire = Salida_valid & Salida_ready.
- Storage: main register (instr, PC), which drives all outputs, plus skid register (instr, PC).
- Three states:
  - VACIO: main empty.
  - LLENO: main full.
  - SKID: main and skid full.
- Salida_valid = (state != VACIO).
- Entrada_ready = (state != SKID).
- Transitions, evaluated when Flush = 0:
  - VACIO: in_fire -> LLENO, main <= input.
  - LLENO: in_fire & out_fire -> LLENO, main <= input.
  - LLENO: in_fire & !out_fire -> SKID, skid <= input.
  - LLENO: !in_fire & out_fire -> VACIO.
  - LLENO: otherwise hold.
  - SKID: out_fire -> LLENO, main <= skid. No input is accepted in SKID.
- Flush has highest priority:
  - Next state is VACIO.
  - Main and skid contents are irrelevant afterwards. Data registers need not be cleared.
  - Any in_fire in the same cycle is consumed and dropped.
  - An out_fire in the same cycle still counts as consumed by decode.
- While Salida_valid & !Salida_ready, all data outputs stay bit-stable.
- Field outputs are combinational slices of the main register. No arithmetic. Widths are exact, with no extension; extension belongs downstream.
- Order is preserved. No entry is duplicated or lost except on Flush.

## Timing
- Reset (asynchronous assert, synchronous deassert at the clk edge):
  - state = VACIO.
  - Salida_valid = 0, Entrada_ready = 1, Es_U = 0, Ilegal = 0.
  - Main and skid registers = 0, so all field outputs and PC_out = 0.
- Reset asserted mid-operation drops all entries immediately, without waiting for clk.
- Latency: an instruction accepted at edge N appears on outputs with Salida_valid = 1 after edge N. This is 1 cycle.
- Throughput: 1 instruction per cycle while Salida_ready = 1.
- Backpressure: one extra entry is absorbed after Salida_ready drops. Entrada_ready falls on the edge that fills the skid register.
- Entrada_ready has no combinational path from Salida_ready, Entrada_valid, or Flush.

## Configuration
- Macro: IFID_ILLEGAL_CHECK_EN.
- Defined:
  - Ilegal = Salida_valid & (held[1:0] != 2'b11 | held == 32'h0000_0000 | held == 32'hFFFF_FFFF).
  - The flag is carried with its entry through the skid path.
- Not defined: Ilegal is tied to 0. The port remains present.

## Test plan
- Reset then idle:
  - rst_n low mid-simulation -> Salida_valid = 0, Entrada_ready = 1, Inmediato_U = 0 with no clk edge.
  - After release with no input, outputs stay unchanged.
- LUI:
  - Stimulus: Instruccion = 32'h7CE737B7, PC_in = 32'h100, Salida_ready = 1.
  - Next cycle -> Inmediato_U = 20'h7CE73, Rd = 15, Opcode = 7'b0110111, Es_U = 1, PC_out = 32'h100.
- AUIPC:
  - Stimulus: Instruccion = 32'hF9CE6097.
  - Response -> Inmediato_U = 20'hF9CE6, Rd = 1, Es_U = 1.
- Backpressure:
  - Stimulus: stream A, B, C with Salida_ready = 0 from cycle 2.
  - Response -> A held stable, B in skid, Entrada_ready = 0, C not accepted.
  - Then raise Salida_ready -> A, B, C emerge in order with no gaps.
- Flush in SKID state with Entrada_valid = 1 -> next cycle Salida_valid = 0, Entrada_ready = 1, and neither held entries nor the incoming entry ever appear.
- Illegal flag:
  - Stimulus: Instruccion = 32'h0000_0000.
  - With IFID_ILLEGAL_CHECK_EN defined -> Ilegal = 1.
  - Without the macro -> Ilegal = 0.
  - With 32'h7CE737B7 -> Ilegal = 0 in both builds.
